// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the serial adder arbiter.
//   state_e   : FSM encoding (IDLE, SHIFT, DONE)
//   req_id_e  : requester index carried on res_id
//   DEFAULT_* : default operand width and bit-counter width
package serial_add_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_e;

    // Priority passes to the requester that was not just served.
    function automatic req_id_e other_id(input req_id_e id);
        return (id == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder datapath: operand shift registers, carry flop,
// result shift register and bit counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b, clear carry, counter and result
//   shift_en   : process one bit pair (LSB first)
//   a, b       : operands sampled on start
//   sum        : result register, filled from the MSB side
//   cout       : carry flop (carry out of MSB once all bits are done)
//   last_bit   : counter is on the final bit position
module serial_add_core
    import serial_add_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             last_bit
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bit_sum;
    logic             bit_carry;

    // Full adder on the current LSBs.
    assign bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // Independent of shift_en so the FSM can qualify it without a comb loop.
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= {bit_sum, sum_q[WIDTH-1:1]};
            carry_q <= bit_carry;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial adder.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req0_*/req1_*           : valid/ready handshake plus operands per requester
//   res_valid/res_ready     : result handshake; result holds until accepted
//   res_sum, res_cout       : sum modulo 2^WIDTH and carry out of the MSB
//   res_id                  : requester that owns the result
//   busy                    : FSM is not in IDLE
module serial_add_arbiter
    import serial_add_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    state_e  state_q, state_d;
    req_id_e prio_q, prio_d;
    req_id_e res_id_q, res_id_d;
    req_id_e grant_id;
    logic    res_valid_q;
    logic    busy_q;
    logic    hs0, hs1;
    logic    start, shift_en, last_bit;
    logic [WIDTH-1:0] core_a, core_b;

    // Grants only in IDLE; the priority holder wins a tie.
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == IDLE) begin
            req0_ready = req0_valid && (prio_q == REQ_ID_0 || !req1_valid);
            req1_ready = req1_valid && (prio_q == REQ_ID_1 || !req0_valid);
        end
    end

    assign hs0    = req0_valid && req0_ready;
    assign hs1    = req1_valid && req1_ready;
    assign start  = hs0 || hs1;
    assign core_a = hs1 ? req1_a : req0_a;
    assign core_b = hs1 ? req1_b : req0_b;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        res_id_d = res_id_q;
        shift_en = 1'b0;
        grant_id = hs1 ? REQ_ID_1 : REQ_ID_0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    res_id_d = grant_id;
                    prio_d   = other_id(grant_id);
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the asynchronous reset clears every flop, including the operand
    // registers, so an aborted addition leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= REQ_ID_0;
            res_id_q    <= REQ_ID_0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            res_id_q    <= res_id_d;
            // Registered from next state so both flags line up with state_q.
            res_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    serial_add_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .shift_en (shift_en),
        .a        (core_a),
        .b        (core_b),
        .sum      (res_sum),
        .cout     (res_cout),
        .last_bit (last_bit)
    );

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter (WIDTH=4): directed scenarios
// plus randomized transactions compared against an arithmetic model.
module tb_serial_add_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id, busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_arbiter #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: sum modulo 2^W and carry out of the MSB.
    function automatic int model_sum(input int a, input int b);
        return (a + b) % (1 << W);
    endfunction

    function automatic int model_cout(input int a, input int b);
        return ((a + b) >= (1 << W)) ? 1 : 0;
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one request and wait (bounded) for its handshake edge.
    // Returns at handshake edge + 1 time unit with valid dropped.
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit ok);
        @(negedge clk);
        if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Count clock edges until res_valid rises (bounded).
    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready} !== '0)
            $display("FAIL reset_outputs: got valid=%b sum=%0d cout=%b id=%b busy=%b rdy=%b%b, expected all 0",
                     res_valid, res_sum, res_cout, res_id, busy, req1_ready, req0_ready);
        else n_pass++;
    endtask

    task automatic check_result(input string name, input int lat, input bit ok,
                                input int exp_sum, input int exp_cout, input int exp_id);
        n_checks++;
        if (!ok || lat != W)
            $display("FAIL %s_latency: got ok=%b lat=%0d, expected lat=%0d", name, ok, lat, W);
        else n_pass++;
        n_checks++;
        if ({res_sum, res_cout, res_id} !== {W'(exp_sum), 1'(exp_cout), 1'(exp_id)})
            $display("FAIL %s_result: got sum=%0d cout=%b id=%b, expected sum=%0d cout=%0d id=%0d",
                     name, res_sum, res_cout, res_id, exp_sum, exp_cout, exp_id);
        else n_pass++;
    endtask

    task automatic test_req0_basic();
        bit ok, vok;
        int lat;
        apply_reset();
        issue(0, 4'd5, 4'd3, ok);
        n_checks++;
        if (!ok) $display("FAIL req0_grant: got no grant, expected grant");
        else n_pass++;
        wait_valid(lat, vok);
        check_result("req0_5p3", lat, vok, 8, 0, 0);
        ack();
    endtask

    task automatic test_req1_carry();
        bit ok, vok;
        int lat;
        apply_reset();
        issue(1, 4'd15, 4'd1, ok);
        n_checks++;
        if (!ok) $display("FAIL req1_grant: got no grant, expected grant");
        else n_pass++;
        wait_valid(lat, vok);
        check_result("req1_15p1", lat, vok, 0, 1, 1);
        ack();
    endtask

    // Both requesters permanently valid, results accepted at once.
    task automatic test_back_to_back();
        int grants[$];
        int ids[$];
        int sums[$];
        int overlap = 0;
        apply_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd5;  req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd1;
        res_ready  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req0_ready && req1_ready) overlap++;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (res_valid) begin
                ids.push_back(int'(res_id));
                sums.push_back(int'(res_sum));
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        n_checks++;
        if (overlap != 0) $display("FAIL b2b_overlap: got %0d double grants, expected 0", overlap);
        else n_pass++;
        n_checks++;
        if (grants.size() < 4 || ids.size() < 3)
            $display("FAIL b2b_count: got %0d grants %0d results, expected >=4 and >=3",
                     grants.size(), ids.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (grants[i] != i % 2)
                    $display("FAIL b2b_grant%0d: got %0d, expected %0d", i, grants[i], i % 2);
                else n_pass++;
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ids[i] != i % 2 || sums[i] != ((i % 2 == 0) ? 8 : 0))
                    $display("FAIL b2b_result%0d: got id=%0d sum=%0d, expected id=%0d sum=%0d",
                             i, ids[i], sums[i], i % 2, (i % 2 == 0) ? 8 : 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        bit ok, vok;
        int lat;
        logic [W-1:0] a, b;
        a = W'($urandom_range(0, 15));
        b = W'($urandom_range(0, 15));
        apply_reset();
        issue(0, a, b, ok);
        wait_valid(lat, vok);
        check_result("hold_first", lat, vok, model_sum(a, b), model_cout(a, b), 0);
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({res_valid, res_sum, res_cout, res_id, req1_ready} !==
                {1'b1, W'(model_sum(a, b)), 1'(model_cout(a, b)), 1'b0, 1'b0})
                $display("FAIL hold_cycle%0d: got valid=%b sum=%0d cout=%b id=%b rdy1=%b, expected 1 %0d %0d 0 0",
                         i, res_valid, res_sum, res_cout, res_id, req1_ready,
                         model_sum(a, b), model_cout(a, b));
            else n_pass++;
        end
        ack();
        n_checks++;
        if ({res_valid, busy, req1_ready} !== 3'b001)
            $display("FAIL hold_release: got valid=%b busy=%b rdy1=%b, expected 0 0 1",
                     res_valid, busy, req1_ready);
        else n_pass++;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit ok, vok;
        int lat;
        int seen = 0;
        apply_reset();
        issue(0, 4'd5, 4'd3, ok);
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_busy: got %b, expected 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready} !== '0)
            $display("FAIL abort_outputs: got valid=%b sum=%0d cout=%b id=%b busy=%b, expected all 0",
                     res_valid, res_sum, res_cout, res_id, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL abort_no_valid: got %0d valid cycles, expected 0", seen);
        else n_pass++;
        issue(1, 4'd9, 4'd9, ok);
        wait_valid(lat, vok);
        check_result("abort_9p9", lat, vok, 2, 1, 1);
        ack();
    endtask

    task automatic test_operand_change();
        bit ok, vok;
        int lat;
        apply_reset();
        issue(0, 4'd5, 4'd3, ok);
        req0_a = 4'd0;
        req0_b = 4'd0;
        wait_valid(lat, vok);
        check_result("opchg", lat, vok, 8, 0, 0);
        ack();
    endtask

    // Random traffic; model tracks round-robin priority by the stated rule.
    task automatic test_random();
        int  prio = 0;
        int  winner, v, lat, hold;
        bit  v0, v1, vok;
        logic [W-1:0] a0, b0, a1, b1;
        int  ea, eb;
        apply_reset();
        for (int t = 0; t < 25; t++) begin
            v  = $urandom_range(1, 3);
            v0 = v[0];
            v1 = v[1];
            a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
            a1 = W'($urandom_range(0, 15)); b1 = W'($urandom_range(0, 15));
            winner = (v0 && v1) ? prio : (v0 ? 0 : 1);
            @(negedge clk);
            req0_valid = v0; req0_a = a0; req0_b = b0;
            req1_valid = v1; req1_a = a1; req1_b = b1;
            #1;
            n_checks++;
            if ({req1_ready, req0_ready} !== ((winner == 0) ? 2'b01 : 2'b10))
                $display("FAIL rand%0d_grant: got rdy1=%b rdy0=%b, expected winner %0d",
                         t, req1_ready, req0_ready, winner);
            else n_pass++;
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            prio = 1 - winner;
            ea = (winner == 0) ? int'(a0) : int'(a1);
            eb = (winner == 0) ? int'(b0) : int'(b1);
            wait_valid(lat, vok);
            hold = $urandom_range(0, 2);
            repeat (hold) @(posedge clk);
            #1;
            check_result($sformatf("rand%0d", t), lat, vok,
                         model_sum(ea, eb), model_cout(ea, eb), winner);
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_req0_basic();
        test_req1_carry();
        test_back_to_back();
        test_hold();
        test_reset_abort();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
